// File: rtl/aludec_seq.sv
// aludec_seq: registered RV32I ALU decoder with an optional iterative RV32M multiply/divide unit.
// Define ALUDEC_RV32M_EN to build the MDU (CALC/FIN states); otherwise every request completes in one cycle.
module aludec_seq #(
  parameter int CTRL_W = 4,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic              opb5,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [XLEN-1:0]   MduResult,
  output logic              busy,
  output logic              done
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8, OP_SRA = 4'd9, OP_PASSB = 4'd10, OP_MDU = 4'd11;

  logic [3:0] base_code;
  always_comb begin
    base_code = OP_ADD;
    case (ALUOp)
      2'b00: base_code = OP_ADD;
      2'b01: case (funct3[2:1])
        2'b10:   base_code = OP_SLT;
        2'b11:   base_code = OP_SLTU;
        default: base_code = OP_SUB;
      endcase
      2'b11: base_code = OP_PASSB;
      default: case (funct3)
        3'b000:  base_code = (funct7b5 & opb5) ? OP_SUB : OP_ADD;
        3'b001:  base_code = OP_SLL;
        3'b010:  base_code = OP_SLT;
        3'b011:  base_code = OP_SLTU;
        3'b100:  base_code = OP_XOR;
        3'b101:  base_code = funct7b5 ? OP_SRA : OP_SRL;
        3'b110:  base_code = OP_OR;
        default: base_code = OP_AND;
      endcase
    endcase
  end

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              done_q, done_d;
  assign ALUControl = ctrl_q;
  assign done       = done_q;

`ifdef ALUDEC_RV32M_EN
  localparam int CNT_W = $clog2(XLEN);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [2*XLEN-1:0] p_q, p_d, prod_s;
  logic [XLEN-1:0]   b_q, b_d, res_q, res_d, mag_a, mag_b, quo_s, rem_s, fin_res;
  logic [2:0]        f3_q, f3_d;
  logic              an_q, an_d, bn_q, bn_d, a_neg, b_neg, is_mdu, div0, ovf;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     madd, dtrial;

  assign is_mdu = (ALUOp == 2'b10) & opb5 & funct7b0;
  assign a_neg  = SrcA[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11));
  assign b_neg  = SrcB[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
  assign mag_a  = a_neg ? -SrcA : SrcA;
  assign mag_b  = b_neg ? -SrcB : SrcB;
  assign div0   = funct3[2] & (SrcB == '0);
  assign ovf    = funct3[2] & ~funct3[0] & (SrcA == {1'b1, {(XLEN-1){1'b0}}}) & (&SrcB);

  // p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide
  assign madd   = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{p_q[0]}} & b_q};
  assign dtrial = p_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign prod_s = (an_q ^ bn_q) ? -p_q : p_q;
  assign quo_s  = (an_q ^ bn_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
  assign rem_s  = an_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];

  always_comb begin
    case (f3_q)
      3'b000:         fin_res = prod_s[XLEN-1:0];
      3'b100, 3'b101: fin_res = quo_s;
      3'b110, 3'b111: fin_res = rem_s;
      default:        fin_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      p_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      an_q    <= 1'b0;
      bn_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      done_q  <= done_d;
      p_q     <= p_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      an_q    <= an_d;
      bn_q    <= bn_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && is_mdu && !div0 && !ovf) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    res_d  = res_q;
    done_d = 1'b0;
    p_d    = p_q;
    b_d    = b_q;
    f3_d   = f3_q;
    an_d   = an_q;
    bn_d   = bn_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (!is_mdu) begin
          ctrl_d = CTRL_W'(base_code);
          done_d = 1'b1;
        end else begin
          ctrl_d = CTRL_W'(OP_MDU);
          if (div0) begin
            res_d  = funct3[1] ? SrcA : '1;
            done_d = 1'b1;
          end else if (ovf) begin
            res_d  = funct3[1] ? '0 : SrcA;
            done_d = 1'b1;
          end else begin
            f3_d  = funct3;
            an_d  = a_neg;
            bn_d  = b_neg;
            cnt_d = '0;
            b_d   = funct3[2] ? mag_b : mag_a;
            p_d   = {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
          end
        end
      end
      S_CALC: begin
        if (f3_q[2])
          p_d = dtrial[XLEN] ? {p_q[2*XLEN-2:0], 1'b0}
                             : {dtrial[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
        else
          p_d = {madd, p_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        res_d  = fin_res;
        done_d = 1'b1;
      end
    endcase
  end

  assign MduResult = res_q;
  assign busy      = (state_q != S_IDLE);
`else
  always_comb begin
    ctrl_d = ctrl_q;
    done_d = 1'b0;
    if (start) begin
      ctrl_d = CTRL_W'(base_code);
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      done_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      done_q <= done_d;
    end
  end

  assign MduResult = '0;
  assign busy      = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{funct7b0, SrcA, SrcB};
`endif
endmodule

// File: tb/tb_aludec_seq.sv
// Directed self-checking bench for aludec_seq; MDU scenarios are built when ALUDEC_RV32M_EN is defined.
module tb_aludec_seq;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [1:0]  ALUOp = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0, funct7b0 = 1'b0, opb5 = 1'b0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [3:0]  ALUControl;
  logic [31:0] MduResult;
  logic        busy, done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  aludec_seq #(.CTRL_W(4), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALUOp(ALUOp), .funct3(funct3),
    .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .MduResult(MduResult), .busy(busy), .done(done)
  );

  task automatic req(input logic [1:0] op, input logic [2:0] f3, input logic f5, f0, ob,
                     input logic [31:0] a, b);
    @(negedge clk);
    ALUOp = op; funct3 = f3; funct7b5 = f5; funct7b0 = f0; opb5 = ob; SrcA = a; SrcB = b;
    start = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0] op; logic [2:0] f3; logic f5; logic ob; logic [3:0] exp;
  } bvec_t;

  bvec_t bv [15] = '{
    '{2'b10, 3'b000, 1'b1, 1'b1, 4'd1},  '{2'b10, 3'b000, 1'b1, 1'b0, 4'd0},
    '{2'b01, 3'b110, 1'b0, 1'b0, 4'd6},  '{2'b10, 3'b101, 1'b1, 1'b0, 4'd9},
    '{2'b11, 3'b000, 1'b0, 1'b0, 4'd10}, '{2'b00, 3'b111, 1'b1, 1'b1, 4'd0},
    '{2'b01, 3'b000, 1'b0, 1'b0, 4'd1},  '{2'b01, 3'b100, 1'b0, 1'b0, 4'd5},
    '{2'b01, 3'b010, 1'b0, 1'b0, 4'd1},  '{2'b10, 3'b001, 1'b0, 1'b1, 4'd7},
    '{2'b10, 3'b010, 1'b0, 1'b1, 4'd5},  '{2'b10, 3'b011, 1'b0, 1'b1, 4'd6},
    '{2'b10, 3'b100, 1'b0, 1'b1, 4'd4},  '{2'b10, 3'b101, 1'b0, 1'b1, 4'd8},
    '{2'b10, 3'b111, 1'b0, 1'b1, 4'd2}
  };

  task automatic test_reset;
    checks++;
    if ({ALUControl, MduResult, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state got ctrl=%h res=%h busy=%b done=%b exp all 0",
               ALUControl, MduResult, busy, done);
    end
  endtask

  task automatic test_base_decode;
    for (int i = 0; i < 15; i++) begin
      req(bv[i].op, bv[i].f3, bv[i].f5, 1'b0, bv[i].ob, 32'h0, 32'h0);
      @(negedge clk); start = 1'b0;
      checks++;
      if (done !== 1'b1 || ALUControl !== bv[i].exp) begin
        errors++;
        $display("FAIL base_decode[%0d] got done=%b ctrl=%0d exp done=1 ctrl=%0d", i, done, ALUControl, bv[i].exp);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ALUControl !== bv[i].exp || busy !== 1'b0) begin
        errors++;
        $display("FAIL base_hold[%0d] got done=%b busy=%b ctrl=%0d exp done=0 busy=0 ctrl=%0d",
                 i, done, busy, ALUControl, bv[i].exp);
      end
    end
  endtask

`ifdef ALUDEC_RV32M_EN
  typedef struct packed {
    logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp; logic [7:0] lat;
  } mvec_t;

  mvec_t mv [12] = '{
    '{3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 8'd34},
    '{3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 8'd34},
    '{3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 8'd34},
    '{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 8'd34},
    '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1},
    '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1},
    '{3'b111, 32'd7, 32'd0, 32'd7, 8'd1},
    '{3'b101, 32'd7, 32'd0, 32'hFFFFFFFF, 8'd1},
    '{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 8'd34},
    '{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 8'd34},
    '{3'b101, 32'd100, 32'd7, 32'd14, 8'd34},
    '{3'b111, 32'd100, 32'd7, 32'd2, 8'd34}
  };

  task automatic test_mdu;
    int lat, nb;
    for (int i = 0; i < 12; i++) begin
      req(2'b10, mv[i].f3, 1'b0, 1'b1, 1'b1, mv[i].a, mv[i].b);
      lat = 0; nb = 0;
      do begin
        @(negedge clk); start = 1'b0; lat++;
        if (busy === 1'b1) nb++;
      end while (done !== 1'b1 && lat < 100);
      checks++;
      if (lat != int'(mv[i].lat) || nb != ((mv[i].lat == 8'd1) ? 0 : 33)) begin
        errors++;
        $display("FAIL mdu_timing[%0d] got lat=%0d busy_cycles=%0d exp lat=%0d", i, lat, nb, mv[i].lat);
      end
      checks++;
      if (MduResult !== mv[i].exp || ALUControl !== 4'd11) begin
        errors++;
        $display("FAIL mdu_result[%0d] got res=%h ctrl=%0d exp res=%h ctrl=11", i, MduResult, ALUControl, mv[i].exp);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mdu_done_pulse[%0d] got done=%b busy=%b exp 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_ignore_busy;
    int lat;
    req(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
    lat = 0;
    do begin
      @(negedge clk);
      start = (lat == 4);
      if (lat == 4) begin funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd5; end
      lat++;
    end while (done !== 1'b1 && lat < 100);
    start = 1'b0;
    checks++;
    if (lat != 34 || MduResult !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL ignore_busy got lat=%0d res=%h exp lat=34 res=fffffffd", lat, MduResult);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    req(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd3, 32'd5);
    lat = 0;
    do begin @(negedge clk); start = 1'b0; lat++; end while (done !== 1'b1 && lat < 100);
    ALUOp = 2'b11; funct7b0 = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || ALUControl !== 4'd10 || MduResult !== 32'd15) begin
      errors++;
      $display("FAIL back_to_back got done=%b ctrl=%0d res=%h exp 1 10 0000000f", done, ALUControl, MduResult);
    end
  endtask

  task automatic test_reset_abort;
    int nd;
    req(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2);
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ALUControl, MduResult, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_abort got ctrl=%h res=%h busy=%b done=%b exp all 0", ALUControl, MduResult, busy, done);
    end
    @(negedge clk); reset_n = 1'b1;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) nd++; end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d active cycles exp 0", nd);
    end
    req(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || ALUControl !== 4'd1) begin
      errors++;
      $display("FAIL reset_recover got done=%b ctrl=%0d exp 1 1", done, ALUControl);
    end
  endtask
`else
  task automatic test_no_mdu;
    req(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2);
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || ALUControl !== 4'd0 || busy !== 1'b0 || MduResult !== 32'd0) begin
      errors++;
      $display("FAIL no_mdu_mul got done=%b ctrl=%0d busy=%b res=%h exp 1 0 0 0", done, ALUControl, busy, MduResult);
    end
    req(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0);
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || ALUControl !== 4'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_mdu_div got done=%b ctrl=%0d busy=%b exp 1 4 0", done, ALUControl, busy);
    end
  endtask

  task automatic test_reset_abort;
    req(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); start = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ALUControl, MduResult, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL reset_abort got ctrl=%h res=%h busy=%b done=%b exp all 0", ALUControl, MduResult, busy, done);
    end
    @(negedge clk); reset_n = 1'b1;
    req(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b1 || ALUControl !== 4'd1) begin
      errors++;
      $display("FAIL reset_recover got done=%b ctrl=%0d exp 1 1", done, ALUControl);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    test_base_decode;
`ifdef ALUDEC_RV32M_EN
    test_mdu;
    test_ignore_busy;
    test_back_to_back;
`else
    test_no_mdu;
`endif
    test_reset_abort;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aludec_seq.md
# aludec_seq

Registered, parametrised ALU decoder for the multi-cycle RV32I core, with an optional iterative multiply/divide unit (MDU). It sits between the main control FSM and the datapath ALU. On a `start` pulse in the execute state it decodes `ALUOp`/`funct3`/`funct7` into a full RV32I ALU operation code. For RV32M instructions it runs a shift-add or restoring-divide sequence and reports completion with a `busy`/`done` handshake.

## Interface
- `CTRL_W`, 4: width of `ALUControl`; must be ≥4; codes are zero-extended.
- `XLEN`, 32: operand and result width; must be even and ≥8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request from the control FSM; sampled only in IDLE.
- `ALUOp` in 2: operation class from maindec.
- `funct3` in 3: instruction funct3.
- `funct7b5` in 1: instruction bit 30.
- `funct7b0` in 1: instruction bit 25 (RV32M select).
- `opb5` in 1: opcode bit 5 (1 = R-type, 0 = I-type).
- `SrcA`, `SrcB` in XLEN: MDU operands; captured on the `start` edge.
- `ALUControl` out CTRL_W: registered ALU operation code.
- `MduResult` out XLEN: registered MDU result.
- `busy` out 1: high while the MDU is iterating.
- `done` out 1: one-cycle pulse; `ALUControl` or `MduResult` is valid.

## Operation
- Codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10, MDU 11.
- ALUOp 00 → ADD.
- ALUOp 01 (branch) → funct3[2:1]: 00 → SUB, 10 → SLT, 11 → SLTU, 01 → SUB.
- ALUOp 11 → PASSB.
- ALUOp 10, funct3 000 → SUB if `funct7b5 & opb5`, else ADD.
- ALUOp 10, other funct3: 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA if `funct7b5` else SRL, 110 OR, 111 AND.
- MDU request: ALUOp 10 with `opb5 & funct7b0`. `funct3` selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- FSM states: IDLE, CALC, FIN.
  - IDLE + `start` + non-MDU → update `ALUControl`, pulse `done`, stay in IDLE.
  - IDLE + `start` + MDU → `ALUControl` = MDU; latch operands, `funct3` and operand signs; go to CALC.
  - CALC runs XLEN iterations on operand magnitudes, then goes to FIN.
  - FIN applies sign correction, registers `MduResult`, pulses `done`, returns to IDLE.
- MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN-bit signed/mixed/unsigned product.
- Divide by zero, short-circuited in IDLE: quotient = all ones; remainder = dividend.
- Signed overflow (DIV/REM with dividend = −2^(XLEN−1), divisor = −1), short-circuited: quotient = dividend; remainder = 0.
- `start` while `busy` is ignored; no queueing.
- `ALUControl` holds its value between requests.

## Timing
- Reset values: `ALUControl` = 0 (ADD), `MduResult` = 0, `busy` = 0, `done` = 0, FSM = IDLE.
- Reset asserted mid-operation aborts the operation immediately; no `done` is produced.
- Non-MDU latency: `done` is high in the cycle after the `start` edge.
- MDU short-circuit cases (div-by-zero, signed overflow) also have latency 1; `busy` stays 0.
- MDU normal latency: `busy` is high for XLEN+1 cycles starting the cycle after `start`. `done` rises XLEN+2 edges after the `start` edge, and `busy` falls in that same cycle.
- `done` is never high for two consecutive cycles. A new `start` is accepted in the same cycle `done` is high.

## Configuration
- `ALUDEC_RV32M_EN`:
  - Defined: the MDU, CALC/FIN states and RV32M decode are compiled in.
  - Undefined: `funct7b0` is ignored and M-pattern instructions decode as base ops by `funct3`. `MduResult` is tied to 0, `busy` is tied to 0, and all requests take latency 1.

## Test plan
- ALUOp 10, funct3 000, `funct7b5` 1, `opb5` 1, `start` → `ALUControl` = 1 and `done` one cycle later. Same with `opb5` 0 (addi) → 0.
- ALUOp 01, funct3 110 → 6. ALUOp 10, funct3 101, `funct7b5` 1 → 9. ALUOp 11 → 10.
- MUL, SrcA 0xFFFFFFFF, SrcB 2 → `busy` for 33 cycles; `done` at edge 34; `MduResult` 0xFFFFFFFE. MULHU on the same operands → 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at latency 1. REMU 7 / 0 → 7. DIVU 7 / 0 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. A second `start` mid-CALC is ignored.
- `reset_n` low at iteration 10 → all outputs 0 and no `done`. A new non-MDU request after release completes normally. With `ALUDEC_RV32M_EN` undefined, MUL decodes to ADD with latency 1.
